// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 320x240 3-bit framebuffer, pixel- and line-doubled.
// A 25 MHz pixel enable is derived from the 50 MHz clock; all VGA outputs lag the counters by one pixel.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_WIDTH = 320
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [16:0] fb_raddr,
  input  logic [2:0]  fb_rdata,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        vblank,
  output logic        frame_pulse
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_en_q, pix_en_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       vga_clk_q, vga_clk_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;
  logic       frame_pulse_q, frame_pulse_d;

  logic       h_vis, v_vis, visible;
  logic [8:0] fb_x, fb_y;

  always_comb begin
    h_vis   = (h_cnt_q < H_VIS);
    v_vis   = (v_cnt_q < V_VIS);
    visible = h_vis && v_vis;
  end

  // Address is combinational so the RAM samples it on the non-pixel edge
  // and its data is ready for the following pixel edge.
  always_comb begin
    fb_x     = h_vis ? h_cnt_q[9:1] : '0;
    fb_y     = v_vis ? v_cnt_q[9:1] : '0;
    fb_raddr = 17'(fb_y) * 17'(FB_WIDTH) + 17'(fb_x);
  end

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    vga_clk_d     = pix_en_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    frame_pulse_d = pix_en_q && (h_cnt_q == H_LAST) && (v_cnt_q == V_VIS_LAST);
    if (pix_en_q) begin
      hs_d      = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
      vs_d      = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
      blank_n_d = visible;
      r_d       = (visible && fb_rdata[2]) ? '1 : '0;
      g_d       = (visible && fb_rdata[1]) ? '1 : '0;
      b_d       = (visible && fb_rdata[0]) ? '1 : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vga_clk_q     <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_pulse_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vga_clk_q     <= vga_clk_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign vblank      = ~v_vis;
  assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: instance a uses full 640x480 timing, instance b keeps full vertical
// timing with an 8-pixel line so whole frames fit in a short run.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  logic [2:0]  rdata_a = 3'b101;
  logic [2:0]  rdata_b = 3'b000;
  logic [16:0] addr_a, addr_b;
  logic        vclk_a, hs_a, vs_a, bl_a, sync_a, vb_a, fp_a;
  logic        vclk_b, hs_b, vs_b, bl_b, sync_b, vb_b, fp_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  vga_scanout dut_a (
    .clk(clk), .resetn(resetn), .fb_raddr(addr_a), .fb_rdata(rdata_a),
    .VGA_CLK(vclk_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a),
    .VGA_SYNC_N(sync_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .vblank(vb_a), .frame_pulse(fp_a)
  );

  vga_scanout #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)) dut_b (
    .clk(clk), .resetn(resetn), .fb_raddr(addr_b), .fb_rdata(rdata_b),
    .VGA_CLK(vclk_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b),
    .VGA_SYNC_N(sync_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .vblank(vb_b), .frame_pulse(fp_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  // cyc == k at the negedge following the k-th rising edge after reset release
  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn && fp_a) pulses_a++;
    if (resetn && fp_b) pulses_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string pfx, input logic [16:0] addr,
                                input logic vclk, input logic hs, input logic vs,
                                input logic bl, input logic [23:0] rgb,
                                input logic vb, input logic fp, input logic sync);
    chk({pfx, "_rst_addr"},  32'(addr), 32'd0);
    chk({pfx, "_rst_vclk"},  32'(vclk), 32'd1);
    chk({pfx, "_rst_hs"},    32'(hs),   32'd1);
    chk({pfx, "_rst_vs"},    32'(vs),   32'd1);
    chk({pfx, "_rst_blank"}, 32'(bl),   32'd0);
    chk({pfx, "_rst_rgb"},   32'(rgb),  32'd0);
    chk({pfx, "_rst_vblank"},32'(vb),   32'd0);
    chk({pfx, "_rst_fp"},    32'(fp),   32'd0);
    chk({pfx, "_sync_n"},    32'(sync), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("a", addr_a, vclk_a, hs_a, vs_a, bl_a, {r_a, g_a, b_a}, vb_a, fp_a, sync_a);
    chk_reset_vals("b", addr_b, vclk_b, hs_b, vs_b, bl_b, {r_b, g_b, b_b}, vb_b, fp_b, sync_b);
    resetn = 1'b1;

    // first pixel edge is the second rising edge
    chk("a_addr_k0", 32'(addr_a), 32'd0);
    wait_cyc(1);
    chk("a_blank_k1", 32'(bl_a), 32'd0);
    chk("a_vclk_k1", 32'(vclk_a), 32'd0);
    wait_cyc(2);
    chk("a_blank_k2", 32'(bl_a), 32'd1);
    chk("a_vclk_k2", 32'(vclk_a), 32'd1);
    chk("a_rgb_101", 32'({r_a, g_a, b_a}), 32'h00FF00FF);
    chk("a_addr_h1", 32'(addr_a), 32'd0);
    wait_cyc(4);
    chk("a_addr_h2", 32'(addr_a), 32'd1);
    wait_cyc(1278);
    chk("a_addr_h639", 32'(addr_a), 32'd319);
    wait_cyc(1280);
    chk("a_addr_hblank", 32'(addr_a), 32'd0);
    wait_cyc(1281);
    chk("a_blank_last", 32'(bl_a), 32'd1);
    wait_cyc(1282);
    chk("a_blank_off", 32'(bl_a), 32'd0);
    chk("a_rgb_off", 32'({r_a, g_a, b_a}), 32'd0);
    wait_cyc(1313);
    chk("a_hs_before", 32'(hs_a), 32'd1);
    wait_cyc(1314);
    chk("a_hs_fall", 32'(hs_a), 32'd0);
    chk("a_vs_line0", 32'(vs_a), 32'd1);
    rdata_a = 3'b111;
    wait_cyc(1402);
    chk("a_rgb_h700", 32'({r_a, g_a, b_a}), 32'd0);
    chk("a_blank_h700", 32'(bl_a), 32'd0);
    wait_cyc(1505);
    chk("a_hs_last_low", 32'(hs_a), 32'd0);
    wait_cyc(1506);
    chk("a_hs_rise", 32'(hs_a), 32'd1);
    rdata_a = 3'b101;
    wait_cyc(1600);
    chk("a_addr_v1h0", 32'(addr_a), 32'd0);
    wait_cyc(2000);
    rdata_a = 3'b010;
    wait_cyc(2001);
    chk("a_rgb_hold", 32'({r_a, g_a, b_a}), 32'h00FF00FF);
    wait_cyc(2002);
    chk("a_rgb_010", 32'({r_a, g_a, b_a}), 32'h0000FF00);
    wait_cyc(2878);
    chk("a_addr_v1h639", 32'(addr_a), 32'd319);
    wait_cyc(3200);
    chk("a_addr_v2h0", 32'(addr_a), 32'd320);
    wait_cyc(3201);
    chk("a_blank_eol", 32'(bl_a), 32'd0);
    wait_cyc(3202);
    chk("a_blank_line1", 32'(bl_a), 32'd1);
    wait_cyc(3204);
    chk("a_addr_v2h2", 32'(addr_a), 32'd321);

    wait_cyc(7664);
    chk("b_addr_v479", 32'(addr_b), 32'd76480);
    wait_cyc(7668);
    chk("b_addr_v479x1", 32'(addr_b), 32'd76481);
    wait_cyc(7679);
    chk("b_vblank_pre", 32'(vb_b), 32'd0);
    chk("b_fp_pre", 32'(fp_b), 32'd0);
    wait_cyc(7680);
    chk("b_vblank_rise", 32'(vb_b), 32'd1);
    chk("b_fp_high", 32'(fp_b), 32'd1);
    wait_cyc(7681);
    chk("b_fp_one_clk", 32'(fp_b), 32'd0);
    wait_cyc(7841);
    chk("b_vs_before", 32'(vs_b), 32'd1);
    wait_cyc(7842);
    chk("b_vs_fall", 32'(vs_b), 32'd0);
    wait_cyc(7873);
    chk("b_vs_last_low", 32'(vs_b), 32'd0);
    wait_cyc(7874);
    chk("b_vs_rise", 32'(vs_b), 32'd1);
    wait_cyc(8399);
    chk("b_vblank_end", 32'(vb_b), 32'd1);
    wait_cyc(8400);
    chk("b_vblank_wrap", 32'(vb_b), 32'd0);
    chk("b_addr_wrap", 32'(addr_b), 32'd0);
    wait_cyc(8404);
    chk("b_addr_wrap_h2", 32'(addr_b), 32'd1);
    wait_cyc(16079);
    chk("b_fp2_pre", 32'(fp_b), 32'd0);
    wait_cyc(16080);
    chk("b_fp2_high", 32'(fp_b), 32'd1);
    wait_cyc(16081);
    chk("b_fp2_low", 32'(fp_b), 32'd0);
    wait_cyc(16500);
    chk("b_pulse_count", 32'(pulses_b), 32'd2);
    chk("a_pulse_count", 32'(pulses_a), 32'd0);

    // asynchronous reset in the middle of a line (a: v=10 h=300)
    wait_cyc(16601);
    chk("a_pre_rst_blank", 32'(bl_a), 32'd1);
    chk("a_pre_rst_vclk", 32'(vclk_a), 32'd0);
    chk("b_pre_rst_vblank", 32'(vb_b), 32'd1);
    resetn = 1'b0;
    #1;
    chk_reset_vals("a", addr_a, vclk_a, hs_a, vs_a, bl_a, {r_a, g_a, b_a}, vb_a, fp_a, sync_a);
    chk_reset_vals("b", addr_b, vclk_b, hs_b, vs_b, bl_b, {r_b, g_b, b_b}, vb_b, fp_b, sync_b);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("a_rel_addr", 32'(addr_a), 32'd0);
    wait_cyc(1);
    chk("a_rel_blank_k1", 32'(bl_a), 32'd0);
    wait_cyc(2);
    chk("a_rel_blank_k2", 32'(bl_a), 32'd1);
    chk("a_rel_hs", 32'(hs_a), 32'd1);
    chk("b_rel_fp", 32'(pulses_b), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read side of the 320x240, 3-bit framebuffer that the game datapath writes via (x, y, colour, plot). Generates 640x480@60 VGA timing from the 50 MHz system clock and line-doubles/pixel-doubles the framebuffer. Issues framebuffer read addresses and expands the 3-bit colour to the 8-bit DAC channels. Also exports a once-per-frame pulse that the game control FSM uses as its replot tick.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch; H_TOTAL = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = 525
- FB_WIDTH, 320, framebuffer row pitch in pixels

Ports:
- clk  in  1  50 MHz system clock; all state on rising edge
- resetn  in  1  reset; asynchronous and active-low
- fb_raddr  out  17  framebuffer read address, y*FB_WIDTH + x
- fb_rdata  in  3  {R,G,B} from synchronous RAM, valid one clk after fb_raddr is sampled
- VGA_CLK  out  1  25 MHz pixel clock to DAC
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- VGA_BLANK_N  out  1  high during visible region
- VGA_SYNC_N  out  1  constant 0
- VGA_R, VGA_G, VGA_B  out  8 each  DAC colour
- vblank  out  1  high while v_cnt >= V_ACTIVE
- frame_pulse  out  1  one-clk pulse at start of vertical blank

## Operation

- pix_en register toggles every clk; reset 0. A "pixel edge" is a clk edge where pix_en == 1 before toggling.
- h_cnt (10 bit, 0..799) increments on each pixel edge; at 799 it wraps to 0 and v_cnt (10 bit, 0..524) increments; v_cnt wraps 524 -> 0.
- fb_raddr is combinational from counters: x = h_cnt[9:1], y = v_cnt[9:1], addr = (y<<8)+(y<<6)+x. Outside the visible region x/y are clamped to 0 (addr 0), never out of 0..76799.
- On each pixel edge, the output registers load from the current counter values and fb_rdata:
  - VGA_BLANK_N = (h_cnt < 640) && (v_cnt < 480).
  - VGA_HS = !(656 <= h_cnt < 752). VGA_VS = !(490 <= v_cnt < 492).
  - Each of VGA_R/G/B = 8'hFF if the corresponding fb_rdata bit (R=bit2, G=bit1, B=bit0) is 1 and the pixel is visible, else 8'h00.
- VGA_CLK = ~pix_en (registered), so the DAC rising edge falls mid-pixel.
- frame_pulse is registered, high for exactly the one clk following the pixel edge on which (h_cnt, v_cnt) advance to (0, 480).
- vblank is combinational from v_cnt.
- No state machine beyond the counters. No handshake: the RAM read port is always enabled.

## Timing

- Counters hold each value for 2 clks. The RAM samples fb_raddr at the non-pixel edge, and fb_rdata is consumed at the following pixel edge.
- Outputs for pixel (h, v) become visible on the pixel edge where the counters advance past (h, v). All VGA outputs therefore lag the counters by exactly one pixel period (2 clks), and stay mutually aligned.
- Line period 1600 clks; hsync low 192 clks. Frame period 840000 clks; vsync low 3200 clks.
- Reset (async, any time, including mid-line): h_cnt = v_cnt = 0, pix_en = 0, VGA_HS = VGA_VS = 1, VGA_BLANK_N = 0, RGB = 0, VGA_CLK = 1, frame_pulse = 0.
  - vblank = 0 after reset (v_cnt = 0).
  - After release, the first pixel edge is the 2nd clk edge; scanning restarts at (0, 0) with no partial frame_pulse.

## Test plan

- Reset mid-line (h=300, v=100) -> all outputs at reset values immediately (async). After release, fb_raddr = 0, and the first pixel edge occurs 2 clks later.
- Free-run one line -> VGA_HS falls 1312 clks after line start (h_cnt=656, +1 pixel lag) for 192 clks; line period 1600 clks; VGA_BLANK_N high for 1280 clks.
- Address sequence -> lines v=0 and v=1 both present 0,0,1,1,...,319,319. Line v=2 starts at 320. (v=479, h=639) gives 76799.
- Colour map: fb_rdata = 3'b101 in visible region -> R = FF, G = 00, B = FF. fb_rdata = 3'b111 with h_cnt = 700 -> RGB = 0, VGA_BLANK_N = 0.
- Full frame -> VGA_VS low for 3200 clks starting at v_cnt = 490. frame_pulse asserted once per 840000 clks, for 1 clk, when vblank rises.
- Wrap at (799, 524) -> next counters are (0, 0), fb_raddr = 0, and vblank falls on the same edge.
